// File: rtl/prog_mem_pkg.sv
// Shared definitions for the loadable program memory: parameter defaults
// and the load/run controller state type.
package prog_mem_pkg;

  localparam int          LINE_WIDTH_DEF = 32;
  localparam int          IP_WIDTH_DEF   = 8;
  localparam logic [31:0] HALT_WORD_DEF  = 32'hffffffff;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } pm_state_t;

  // Address bits needed to index n entries (at least one bit).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_mem_line_ram.sv
// DEPTH x LINE_WIDTH line store: one synchronous write port and one
// synchronous read port, no reset (contents are gated by the loaded length).
module line_ram #(
  parameter int LINE_WIDTH = 32,
  parameter int AW         = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [LINE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [LINE_WIDTH-1:0] rdata
);

  logic [LINE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Loadable program memory: byte-serial loader assembling MSB-first lines into
// line_ram, and a one-cycle registered fetch port with halt-word substitution.
//
// state  | meaning
// S_IDLE | after reset, nothing loaded, fetches ignored
// S_LOAD | accepting load bytes, ld_ready high
// S_RUN  | program loaded, fetches served
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int                    LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int                    IP_WIDTH   = IP_WIDTH_DEF,
  parameter int                    DEPTH      = 1 << IP_WIDTH,
  parameter logic [LINE_WIDTH-1:0] HALT_WORD  = LINE_WIDTH'(HALT_WORD_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  load_done,
  output logic [IP_WIDTH:0]     length,
  input  logic                  fetch_req,
  input  logic [IP_WIDTH-1:0]   ip,
  output logic [LINE_WIDTH-1:0] line,
  output logic                  line_valid,
  output logic                  halt
);

  localparam int BYTES = LINE_WIDTH / 8;
  localparam int BW    = idx_bits(BYTES);
  localparam int MW    = idx_bits(DEPTH);

  pm_state_t             state;
  logic [MW-1:0]         wr_addr;
  logic [BW-1:0]         byte_cnt;
  logic [LINE_WIDTH-1:0] asm_q;
  logic [LINE_WIDTH-1:0] asm_next;
  logic [LINE_WIDTH-1:0] wdata;
  logic [LINE_WIDTH-1:0] rdata;
  logic [IP_WIDTH:0]     length_q;
  logic                  hs;
  logic                  line_end;
  logic                  load_end;
  logic                  fetch_go;
  logic                  in_range;
  logic                  past_q;
  logic                  fetched_q;

  assign ld_ready = (state == S_LOAD);
  assign hs       = ld_valid && ld_ready;
  assign asm_next = (asm_q << 8) | LINE_WIDTH'(ld_byte);
  assign line_end = hs && (ld_last || (byte_cnt == BW'(BYTES - 1)));
  assign load_end = line_end && (ld_last || (wr_addr == MW'(DEPTH - 1)));

  // A short final line is left-justified so the missing low bytes read as zero.
  assign wdata    = asm_next << (8 * (BYTES - 1 - int'(byte_cnt)));

  assign fetch_go = fetch_req && (state == S_RUN);
  assign in_range = {1'b0, ip} < length_q;
  assign length   = length_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_addr    <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      length_q   <= '0;
      load_done  <= 1'b0;
      line_valid <= 1'b0;
      past_q     <= 1'b1;
      fetched_q  <= 1'b0;
    end else begin
      load_done  <= 1'b0;
      line_valid <= fetch_go;
      if (fetch_go) begin
        past_q    <= !in_range;
        fetched_q <= 1'b1;
      end
      case (state)
        S_IDLE, S_RUN: begin
          if (load_start) begin
            state    <= S_LOAD;
            wr_addr  <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            length_q <= '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            if (line_end) begin
              asm_q    <= '0;
              byte_cnt <= '0;
              wr_addr  <= wr_addr + 1'b1;
              length_q <= length_q + 1'b1;
            end else begin
              asm_q    <= asm_next;
              byte_cnt <= byte_cnt + 1'b1;
            end
            if (load_end) begin
              state     <= S_RUN;
              load_done <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  line_ram #(
    .LINE_WIDTH (LINE_WIDTH),
    .AW         (MW),
    .DEPTH      (DEPTH)
  ) u_line_ram (
    .clk   (clk),
    .we    (line_end),
    .waddr (wr_addr),
    .wdata (wdata),
    .re    (fetch_go && in_range),
    .raddr (ip[MW-1:0]),
    .rdata (rdata)
  );

  // rdata only moves on an in-range fetch, so line holds between fetches.
  assign line = past_q ? HALT_WORD : rdata;
  assign halt = fetched_q && (line == HALT_WORD);

endmodule
